accelerator_hls_deadlock_reporter: RTL

ACCELERATOR_HLS_DEADLOCK_REPORTER -- requirements
Module: accelerator_hls_deadlock_reporter

---
 rtl/accelerator_hls_deadlock_pkg.sv | 7 +
 rtl/accelerator_hls_deadlock_first_set.sv | 15 +
 rtl/accelerator_hls_deadlock_reporter.sv | 97 +++++++++
 3 files changed

// File: rtl/accelerator_hls_deadlock_pkg.sv
// accelerator_hls_deadlock_pkg: shared widths and FSM state type for the deadlock reporter
package accelerator_hls_deadlock_pkg;
  localparam int REPORT_COUNT_W = 8;
  localparam int CONFIRM_CNT_W = 16;
  localparam int TIMESTAMP_W = 32;
  typedef enum logic [1:0] {ST_IDLE, ST_CONFIRM, ST_REPORT, ST_HOLD} state_e;
endpackage

// File: rtl/accelerator_hls_deadlock_first_set.sv
// accelerator_hls_deadlock_first_set: lowest-set-index priority encoder with any-set flag
module accelerator_hls_deadlock_first_set #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] sigs,
  output logic [W-1:0] idx,
  output logic         any
);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (sigs[i]) idx = W'(i);
  end
  assign any = |sigs;
endmodule

// File: rtl/accelerator_hls_deadlock_reporter.sv
// accelerator_hls_deadlock_reporter: confirms a persistent monitor block and offers one report per arm.
// Optional report_time output enabled by DEADLOCK_REPORTER_TIMESTAMP_EN.
module accelerator_hls_deadlock_reporter
  import accelerator_hls_deadlock_pkg::*;
#(
  parameter int NUM_MONITORS = 4,
  parameter int CONFIRM_CYCLES = 16,
  localparam int IDX_W = NUM_MONITORS > 1 ? $clog2(NUM_MONITORS) : 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_MONITORS-1:0]   block_sigs,
  input  logic                      clear,
  output logic                      report_valid,
  input  logic                      report_ready,
  output logic [IDX_W-1:0]          report_idx,
  output logic                      deadlock_flag,
`ifdef DEADLOCK_REPORTER_TIMESTAMP_EN
  output logic [REPORT_COUNT_W-1:0] report_count,
  output logic [TIMESTAMP_W-1:0]    report_time
`else
  output logic [REPORT_COUNT_W-1:0] report_count
`endif
);
  localparam logic [CONFIRM_CNT_W-1:0] CC = CONFIRM_CNT_W'(CONFIRM_CYCLES);
  state_e                    state_q, state_d;
  logic [CONFIRM_CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]          cand_q, cand_d, first_idx;
  logic [REPORT_COUNT_W-1:0] count_q, count_d;
  logic                      any_set, hs;
  accelerator_hls_deadlock_first_set #(.N(NUM_MONITORS), .W(IDX_W)) u_first (
    .sigs(block_sigs),
    .idx (first_idx),
    .any (any_set)
  );
  assign hs = state_q == ST_REPORT && report_ready;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    count_d = hs && count_q != '1 ? count_q + 8'd1 : count_q;
    case (state_q)
      ST_IDLE: if (any_set) begin
        cand_d  = first_idx;
        cnt_d   = 16'd1;
        state_d = CONFIRM_CYCLES == 1 ? ST_REPORT : ST_CONFIRM;
      end
      ST_CONFIRM: if (clear || !block_sigs[cand_q]) begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end else begin
        cnt_d   = cnt_q + 16'd1;
        state_d = cnt_d == CC ? ST_REPORT : ST_CONFIRM;
      end
      // clear is deliberately ignored while a report is outstanding
      ST_REPORT: state_d = report_ready ? ST_HOLD : ST_REPORT;
      default: if (clear) begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      count_q <= count_d;
    end
  end
  assign report_valid  = state_q == ST_REPORT;
  assign deadlock_flag = state_q == ST_REPORT || state_q == ST_HOLD;
  assign report_idx    = deadlock_flag ? cand_q : '0;
  assign report_count  = count_q;
`ifdef DEADLOCK_REPORTER_TIMESTAMP_EN
  logic [TIMESTAMP_W-1:0] ts_q, ts_d, time_q, time_d;
  always_comb begin
    ts_d   = ts_q + 32'd1;
    time_d = state_d == ST_REPORT && state_q != ST_REPORT ? ts_q : time_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ts_q   <= '0;
      time_q <= '0;
    end else begin
      ts_q   <= ts_d;
      time_q <= time_d;
    end
  end
  assign report_time = time_q;
`endif
endmodule
